// File: rtl/multi_blink.sv
// Multi-channel LED/indicator driver: shared prescaler tick feeding per-channel
// OFF / ON / BLINK / BURST engines configured through a single write port.
module multi_blink #(
    parameter int NCH      = 4,
    parameter int PRESCALE = 25000,
    parameter int PW       = 8,
    parameter int CW       = 4,
    localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_valid,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [1:0]     cfg_mode,
    input  logic [PW-1:0]  cfg_period,
    input  logic [CW-1:0]  cfg_count,
    output logic [NCH-1:0] B,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] done
);

    localparam int PSW = $clog2(PRESCALE);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ON    = 2'd1,
        ST_BLINK = 2'd2,
        ST_BURST = 2'd3
    } ch_state_e;

    logic [PSW-1:0] pre_q;
    logic [PSW-1:0] pre_d;
    logic           tick;

    ch_state_e      state_q  [NCH];
    logic [PW-1:0]  phase_q  [NCH];
    logic [PW-1:0]  period_q [NCH];
    logic [CW-1:0]  rem_q    [NCH];
    logic [NCH-1:0] b_q;
    logic [NCH-1:0] done_q;
    logic [NCH-1:0] zdone_q;
    logic [NCH-1:0] wr_hit;

    always_comb begin
        tick  = (pre_q == PSW'(PRESCALE - 1));
        pre_d = tick ? '0 : pre_q + PSW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    // Indices outside 0..NCH-1 never match a channel, so such writes vanish.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_hit[i] = cfg_valid && (cfg_ch == CHW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_q     <= '0;
            done_q  <= '0;
            zdone_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i]  <= ST_OFF;
                phase_q[i]  <= '0;
                period_q[i] <= '0;
                rem_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                // A zero-length burst reports completion one cycle after the write.
                done_q[i]  <= zdone_q[i];
                zdone_q[i] <= 1'b0;
                if (wr_hit[i]) begin
                    phase_q[i]  <= '0;
                    period_q[i] <= (cfg_period == '0) ? PW'(1) : cfg_period;
                    rem_q[i]    <= cfg_count;
                    case (cfg_mode)
                        2'd0: begin
                            state_q[i] <= ST_OFF;
                            b_q[i]     <= 1'b0;
                        end
                        2'd1: begin
                            state_q[i] <= ST_ON;
                            b_q[i]     <= 1'b1;
                        end
                        2'd2: begin
                            state_q[i] <= ST_BLINK;
                            b_q[i]     <= 1'b1;
                        end
                        default: begin
                            if (cfg_count == '0) begin
                                state_q[i] <= ST_OFF;
                                b_q[i]     <= 1'b0;
                                zdone_q[i] <= 1'b1;
                            end else begin
                                state_q[i] <= ST_BURST;
                                b_q[i]     <= 1'b1;
                            end
                        end
                    endcase
                end else if (tick && (state_q[i] == ST_BLINK || state_q[i] == ST_BURST)) begin
                    if (phase_q[i] == period_q[i] - PW'(1)) begin
                        phase_q[i] <= '0;
                        if (state_q[i] == ST_BURST && b_q[i]) begin
                            b_q[i] <= 1'b0;
                            if (rem_q[i] == CW'(1)) begin
                                state_q[i] <= ST_OFF;
                                rem_q[i]   <= '0;
                                done_q[i]  <= 1'b1;
                            end else begin
                                rem_q[i] <= rem_q[i] - CW'(1);
                            end
                        end else begin
                            b_q[i] <= ~b_q[i];
                        end
                    end else begin
                        phase_q[i] <= phase_q[i] + PW'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < NCH; i++) begin
            busy[i] = (state_q[i] == ST_BLINK) || (state_q[i] == ST_BURST);
        end
    end

    assign B    = b_q;
    assign done = done_q;

endmodule

// File: tb/tb_multi_blink.sv
// Directed bench for multi_blink with PRESCALE=4; a second NCH=5 instance
// exercises channel indices that are representable but out of range.
module tb_multi_blink;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [1:0] cfg_mode = '0;
    logic [7:0] cfg_period = '0;
    logic [3:0] cfg_count = '0;
    logic [3:0] B, busy, done;

    logic       cfg_valid5 = 1'b0;
    logic [2:0] cfg_ch5 = '0;
    logic [4:0] B5, busy5, done5;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Mirrors the free-running prescaler: prescaler value == cyc % 4.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    multi_blink #(.NCH(4), .PRESCALE(4), .PW(8), .CW(4)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_count(cfg_count),
        .B(B), .busy(busy), .done(done)
    );

    multi_blink #(.NCH(5), .PRESCALE(4), .PW(8), .CW(4)) dut5 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid5), .cfg_ch(cfg_ch5),
        .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_count(cfg_count),
        .B(B5), .busy(busy5), .done(done5)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [1:0] ch, input logic [1:0] mode,
                           input logic [7:0] per, input logic [3:0] cnt);
        cfg_valid  = 1'b1;
        cfg_ch     = ch;
        cfg_mode   = mode;
        cfg_period = per;
        cfg_count  = cnt;
    endtask

    task automatic wait_phase(input int k);
        repeat (4) begin
            if ((cyc % 4) != k) step();
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        n_cmp++;
        if (B !== 4'b0 || busy !== 4'b0 || done !== 4'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got B=%b busy=%b done=%b, want all 0000", B, busy, done);
        end
        n_cmp++;
        if (B5 !== 5'b0 || busy5 !== 5'b0 || done5 !== 5'b0) begin
            n_err++;
            $display("FAIL reset_outputs5: got B=%b busy=%b done=%b, want all 0", B5, busy5, done5);
        end
        rst = 1'b0;
        for (int n = 0; n < 12; n++) begin
            n_cmp++;
            if (dut.tick !== ((n % 4) == 3)) begin
                n_err++;
                $display("FAIL tick_cadence n=%0d: got %b want %b", n, dut.tick, ((n % 4) == 3));
            end
            step();
        end
    endtask

    task automatic test_blink();
        logic [3:0] exp_b;
        wait_phase(0);
        set_cfg(2'd2, 2'd2, 8'd2, 4'd0);
        step();
        cfg_valid = 1'b0;
        for (int r = 1; r <= 31; r++) begin
            exp_b    = 4'b0;
            exp_b[2] = ((r / 8) % 2) == 0;
            exp_b[0] = (r >= 11);
            n_cmp++;
            if (B !== exp_b || busy !== 4'b0100 || done !== 4'b0) begin
                n_err++;
                $display("FAIL blink r=%0d: got B=%b busy=%b done=%b want B=%b busy=0100 done=0000",
                         r, B, busy, done, exp_b);
            end
            if (r == 10) set_cfg(2'd0, 2'd1, 8'd0, 4'd0);
            else         cfg_valid = 1'b0;
            step();
        end
        set_cfg(2'd2, 2'd0, 8'd0, 4'd0);
        step();
        set_cfg(2'd0, 2'd0, 8'd0, 4'd0);
        n_cmp++;
        if (B !== 4'b0001 || busy !== 4'b0000) begin
            n_err++;
            $display("FAIL blink_stop_ch2: got B=%b busy=%b want B=0001 busy=0000", B, busy);
        end
        step();
        cfg_valid = 1'b0;
        n_cmp++;
        if (B !== 4'b0000 || busy !== 4'b0000) begin
            n_err++;
            $display("FAIL blink_stop_ch0: got B=%b busy=%b want B=0000 busy=0000", B, busy);
        end
    endtask

    task automatic test_burst();
        logic [3:0] exp_b, exp_busy, exp_done;
        wait_phase(3);
        set_cfg(2'd1, 2'd3, 8'd1, 4'd3);
        step();
        cfg_valid = 1'b0;
        for (int r = 1; r <= 24; r++) begin
            exp_b       = 4'b0;
            exp_b[1]    = (r <= 20) && ((((r - 1) / 4) % 2) == 0);
            exp_busy    = (r <= 20) ? 4'b0010 : 4'b0000;
            exp_done    = (r == 21) ? 4'b0010 : 4'b0000;
            n_cmp++;
            if (B !== exp_b || busy !== exp_busy || done !== exp_done) begin
                n_err++;
                $display("FAIL burst r=%0d: got B=%b busy=%b done=%b want B=%b busy=%b done=%b",
                         r, B, busy, done, exp_b, exp_busy, exp_done);
            end
            step();
        end
    endtask

    task automatic test_burst_zero();
        set_cfg(2'd0, 2'd3, 8'd5, 4'd0);
        step();
        cfg_valid = 1'b0;
        n_cmp++;
        if (B !== 4'b0 || busy !== 4'b0 || done !== 4'b0) begin
            n_err++;
            $display("FAIL burst0_r1: got B=%b busy=%b done=%b want 0000/0000/0000", B, busy, done);
        end
        step();
        n_cmp++;
        if (B !== 4'b0 || busy !== 4'b0 || done !== 4'b0001) begin
            n_err++;
            $display("FAIL burst0_r2: got B=%b busy=%b done=%b want 0000/0000/0001", B, busy, done);
        end
        step();
        n_cmp++;
        if (done !== 4'b0) begin
            n_err++;
            $display("FAIL burst0_r3: got done=%b want 0000", done);
        end
        set_cfg(2'd0, 2'd1, 8'd0, 4'd0);
        step();
        cfg_valid = 1'b0;
        n_cmp++;
        if (B !== 4'b0001 || busy !== 4'b0) begin
            n_err++;
            $display("FAIL on_mode: got B=%b busy=%b want B=0001 busy=0000", B, busy);
        end
        set_cfg(2'd0, 2'd0, 8'd0, 4'd0);
        step();
        cfg_valid = 1'b0;
        n_cmp++;
        if (B !== 4'b0 || busy !== 4'b0) begin
            n_err++;
            $display("FAIL off_mode: got B=%b busy=%b want B=0000 busy=0000", B, busy);
        end
    endtask

    task automatic test_terminal_write();
        logic [3:0] exp_b, exp_busy, exp_done;
        wait_phase(3);
        set_cfg(2'd3, 2'd3, 8'd1, 4'd1);
        step();
        cfg_valid = 1'b0;
        for (int r = 1; r <= 18; r++) begin
            exp_b    = 4'b0;
            exp_b[3] = (r <= 8) || (r >= 13 && r <= 16);
            exp_busy = (r <= 16) ? 4'b1000 : 4'b0000;
            exp_done = (r == 17) ? 4'b1000 : 4'b0000;
            n_cmp++;
            if (B !== exp_b || busy !== exp_busy || done !== exp_done) begin
                n_err++;
                $display("FAIL terminal_write r=%0d: got B=%b busy=%b done=%b want B=%b busy=%b done=%b",
                         r, B, busy, done, exp_b, exp_busy, exp_done);
            end
            if (r == 4) set_cfg(2'd3, 2'd3, 8'd1, 4'd2);
            else        cfg_valid = 1'b0;
            step();
        end
    endtask

    task automatic test_out_of_range();
        cfg_valid  = 1'b0;
        cfg_period = 8'd1;
        cfg_count  = 4'd2;
        cfg_valid5 = 1'b1;
        cfg_ch5    = 3'd4;
        cfg_mode   = 2'd1;
        step();
        n_cmp++;
        if (B5 !== 5'b10000 || busy5 !== 5'b0) begin
            n_err++;
            $display("FAIL oor_ch4_on: got B=%b busy=%b want B=10000 busy=00000", B5, busy5);
        end
        cfg_ch5  = 3'd5;
        cfg_mode = 2'd2;
        step();
        n_cmp++;
        if (B5 !== 5'b10000 || busy5 !== 5'b0) begin
            n_err++;
            $display("FAIL oor_ch5: got B=%b busy=%b want B=10000 busy=00000", B5, busy5);
        end
        cfg_ch5  = 3'd7;
        cfg_mode = 2'd0;
        step();
        n_cmp++;
        if (B5 !== 5'b10000 || busy5 !== 5'b0 || done5 !== 5'b0) begin
            n_err++;
            $display("FAIL oor_ch7: got B=%b busy=%b done=%b want 10000/00000/00000", B5, busy5, done5);
        end
        cfg_ch5  = 3'd4;
        cfg_mode = 2'd0;
        step();
        cfg_valid5 = 1'b0;
        n_cmp++;
        if (B5 !== 5'b0 || B !== 4'b0) begin
            n_err++;
            $display("FAIL oor_ch4_off: got B5=%b B=%b want 00000/0000", B5, B);
        end
    endtask

    task automatic test_reset_mid();
        set_cfg(2'd1, 2'd3, 8'd2, 4'd5);
        step();
        cfg_valid = 1'b0;
        n_cmp++;
        if (B !== 4'b0010 || busy !== 4'b0010) begin
            n_err++;
            $display("FAIL rstmid_start: got B=%b busy=%b want 0010/0010", B, busy);
        end
        rst = 1'b1;
        set_cfg(2'd0, 2'd1, 8'd0, 4'd0);
        step();
        rst = 1'b0;
        cfg_valid = 1'b0;
        n_cmp++;
        if (B !== 4'b0 || busy !== 4'b0 || done !== 4'b0) begin
            n_err++;
            $display("FAIL rstmid_edge: got B=%b busy=%b done=%b want all 0000", B, busy, done);
        end
        for (int r = 0; r < 10; r++) begin
            step();
            n_cmp++;
            if (B !== 4'b0 || busy !== 4'b0 || done !== 4'b0) begin
                n_err++;
                $display("FAIL rstmid_after r=%0d: got B=%b busy=%b done=%b want all 0000",
                         r, B, busy, done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_blink();
        test_burst();
        test_burst_zero();
        test_terminal_write();
        test_out_of_range();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
